alu_issue_buffer: RTL
=====================

// Module: alu_issue_buffer
// PURPOSE
//   Execute-stage front end. Buffers ALU requests {op, A, B} in a DEPTH-entry FIFO
//   and presents the head entry to the 32-bit ALU's combinational inputs.
//   Captures the ALU's res/zero into an output register with a valid/ready handshake.
//   Decouples the issuing stage from the writeback consumer; ALU ops complete in order.
// PARAMETERS
//   DEPTH  4   FIFO entries; power of two, >= 2
//   W      32  operand/result width; must match the ALU
// PORTS
//   clk        in   1             rising-edge clock
//   rst_n      in   1             asynchronous, active-low reset
//   in_valid   in   1             request present
//   in_ready   out  1             FIFO can accept; = !full
//   in_op      in   3             ALU op code (0 and,1 or,2 add,3 xor,4 nor,5 srl,6 sub,7 slt)
//   in_a       in   W             operand A
//   in_b       in   W             operand B
//   alu_a      out  W             head A to ALU; 0 when FIFO empty
//   alu_b      out  W             head B to ALU; 0 when FIFO empty
//   alu_op     out  3             head op to ALU; 0 when FIFO empty
//   alu_res    in   W             ALU result (combinational from alu_a/b/op)
//   alu_zero   in   1             ALU zero flag
//   out_valid  out  1             registered result present
//   out_ready  in   1             consumer accepts result
//   out_res    out  W             registered result
//   out_zero   out  1             registered zero flag
//   out_op     out  3             op code that produced out_res
//   count      out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH (excludes output reg)
// BEHAVIOUR
//   - Reset (rst_n=0, async): rd/wr pointers and count = 0; out_valid = 0;
//     out_res = 0; out_zero = 0; out_op = 0. FIFO storage not cleared.
//     Reset mid-operation discards all queued and held results; in_ready = 1 from the
//     first edge after release.
//   - Push: in_valid & in_ready at a rising edge writes the entry at wr_ptr and
//     increments wr_ptr modulo DEPTH.
//   - Full: push while full is ignored; in_ready = 0. No push-through when full,
//     even if a pop happens in the same cycle.
//   - Capture: cap = !empty & (!out_valid | out_ready). On cap, register alu_res,
//     alu_zero and head op into out_*; set out_valid = 1; pop head (rd_ptr+1 mod DEPTH).
//   - Drain: out_valid & out_ready & !cap -> out_valid = 0; out_res/out_zero/out_op
//     hold their last values.
//   - Hold: out_valid & !out_ready -> out_* stable; no pop.
//   - Simultaneous push + capture: count unchanged. Empty + push: no capture that
//     cycle; head becomes visible next cycle.
//   - Latency: push at edge N -> head on alu_* after N -> captured at edge N+1
//     -> out_valid high in cycle N+1..N+2 window, i.e. 2 edges push-to-result.
//   - Throughput: 1 result/cycle when out_ready stays 1 and FIFO non-empty.
//   - Capacity: DEPTH queued + 1 held in the output register.
//   - Pointers: $clog2(DEPTH) bits with wrap; full/empty derived from count.
//   - count is registered and updates on the same edge as push/pop.
// TESTING
//   1. push {op=2, A=5, B=3}, out_ready=1 -> out_valid after 2 edges, out_res=8, out_zero=0, out_op=2.
//   2. push {6, 7, 7} -> out_res=0, out_zero=1; push {7, 3, 9} -> out_res=1 (slt).
//   3. out_ready=0, push 6 requests -> 5 accepted (4 queued + 1 held), count=4,
//      in_ready=0; raise out_ready -> results drain in push order, 1 per cycle.
//   4. Stream 10 back-to-back adds with out_ready=1 -> 10 results in order;
//      pointer wrap covered; count never exceeds 1.
//   5. Toggle out_ready 1/0 every cycle during a 6-request stream -> no loss, no
//      duplication; out_* stable while out_valid & !out_ready.
//   6. Assert rst_n low mid-stream with count=3, out_valid=1 -> immediately out_valid=0,
//      count=0, out_res=0; after release a new request completes normally.

Source files
------------

// File: rtl/alu_issue_buffer.sv
// alu_issue_buffer
//   Execute-stage front end. Queues ALU requests {op, a, b} in a DEPTH-entry FIFO,
//   presents the head entry to an external combinational 32-bit ALU and captures the
//   ALU result into an output register with a valid/ready handshake. Results leave
//   in request order. Capacity is DEPTH queued entries plus one held result.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       request handshake (in_ready = !full)
//   in_op, in_a, in_b       request op code and operands
//   alu_op, alu_a, alu_b    head entry driven to the ALU (all zero when empty)
//   alu_res, alu_zero       ALU result and zero flag
//   out_valid/out_ready     result handshake
//   out_res, out_zero,      registered result, zero flag and the op that made it
//   out_op
//   count                   FIFO occupancy 0..DEPTH (output register excluded)

module alu_issue_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_op,
    input  logic [W-1:0]             in_a,
    input  logic [W-1:0]             in_b,
    output logic [W-1:0]             alu_a,
    output logic [W-1:0]             alu_b,
    output logic [2:0]               alu_op,
    input  logic [W-1:0]             alu_res,
    input  logic                     alu_zero,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_res,
    output logic                     out_zero,
    output logic [2:0]               out_op,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    // FIFO storage is intentionally left out of reset.
    logic [W-1:0] a_mem  [DEPTH];
    logic [W-1:0] b_mem  [DEPTH];
    logic [2:0]   op_mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_res_q, out_res_d;
    logic         out_zero_q, out_zero_d;
    logic [2:0]   out_op_q, out_op_d;

    logic empty;
    logic full;
    logic push;
    logic cap;

    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == CW'(DEPTH));
        // Full blocks the push even if a capture frees a slot on the same edge.
        push  = in_valid & ~full;
        // Capture whenever the output register is free or being drained this cycle.
        cap   = ~empty & (~out_valid_q | out_ready);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (cap) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({push, cap})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_res_d   = out_res_q;
        out_zero_d  = out_zero_q;
        out_op_d    = out_op_q;
        if (cap) begin
            out_valid_d = 1'b1;
            out_res_d   = alu_res;
            out_zero_d  = alu_zero;
            out_op_d    = op_mem[rd_ptr_q];
        end else if (out_ready) begin
            // Drain: data fields keep their last values.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            a_mem[wr_ptr_q]  <= in_a;
            b_mem[wr_ptr_q]  <= in_b;
            op_mem[wr_ptr_q] <= in_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_zero_q  <= 1'b0;
            out_op_q    <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
            out_zero_q  <= out_zero_d;
            out_op_q    <= out_op_d;
        end
    end

    always_comb begin
        in_ready  = ~full;
        alu_a     = empty ? '0 : a_mem[rd_ptr_q];
        alu_b     = empty ? '0 : b_mem[rd_ptr_q];
        alu_op    = empty ? '0 : op_mem[rd_ptr_q];
        out_valid = out_valid_q;
        out_res   = out_res_q;
        out_zero  = out_zero_q;
        out_op    = out_op_q;
        count     = count_q;
    end

endmodule
